operand_arbiter: RTL and testbench
==================================

Name: operand_arbiter

Overview:
- Shares the 8-bit operand path (2:1 mux, select `c`) between two requesters.
- Requesters issue bursts of 8-bit beats.
- The block grants one requester at a time with round-robin fairness and drives the mux select.
- It registers the selected beat toward the downstream ALU/register stage with a valid/ready handshake.

Parameters:
- MAX_BEATS, 4, maximum beats per grant before forced release (1..15).
- CNT_W, 4, width of the beat counter; must hold MAX_BEATS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 has a valid beat on data0
- data0  input  8  requester 0 beat
- last0  input  1  beat on data0 is the final beat of its burst
- req1  input  1  requester 1 has a valid beat on data1
- data1  input  8  requester 1 beat
- last1  input  1  beat on data1 is the final beat of its burst
- gnt0  output  1  requester 0 owns the path; its beat is consumed when gnt0 & req0 & accept
- gnt1  output  1  requester 1 owns the path
- sel  output  1  mux select (0 = data0, 1 = data1); drives the mux `c` input
- out_data  output  8  registered beat to downstream
- out_valid  output  1  out_data holds an unconsumed beat
- out_ready  input  1  downstream consumes out_data this cycle

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values:
  - gnt0 = 0, gnt1 = 0, sel = 0
  - out_valid = 0, out_data = 8'h00
  - state = IDLE, beat counter = 0
  - last_served = 1, so requester 0 wins the first tie.
- States: IDLE, OWN0, OWN1. gnt0 = (state == OWN0); gnt1 = (state == OWN1). sel is registered; it is 1 in OWN1 and holds its previous value in IDLE.
- IDLE transitions:
  - Only req0 → OWN0 next cycle.
  - Only req1 → OWN1 next cycle.
  - Both → the requester other than last_served.
  - Neither → stay in IDLE.
  - Arbitration latency is 1 cycle from req to gnt.
- Accept: accept = !out_valid | out_ready. A beat transfers on a cycle where gnt_i & req_i & accept. On transfer, out_data <= data_i and out_valid <= 1 on the next edge.
- out_valid clears on out_ready when no new beat transfers the same cycle. Throughput is 1 beat/cycle under continuous out_ready.
- Beat counter: increments on each transferred beat and resets to 0 on every grant change.
- Release from OWNi occurs on any of:
  - (a) a transferred beat with last_i = 1
  - (b) a transferred beat that brings the counter to MAX_BEATS
  - (c) req_i = 0 while granted (requester abandoned)
- On release, last_served <= i.
  - If the other requester's req is high that cycle, go directly to OWN(other).
  - Otherwise go to IDLE.
  - The same requester is never re-granted without passing through IDLE.
- Stall: req_i = 1 with accept = 0 holds the grant, counter and out_data unchanged, with no release.
- Simultaneous events: a burst ending on a forced release with last_i = 1 counts once. If both reqs rise in the same IDLE cycle, apply the round-robin rule.
- Reset mid-burst clears all state immediately, asynchronously, and drops any held beat (out_valid = 0).
- At most one of gnt0/gnt1 is high in any cycle (invariant).

Decomposition:
- Shared package/include: state encodings (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2) and the default MAX_BEATS constant.
- The operand mux is instantiated inside as the existing mux2 module (e0 = data0, e1 = data1, c = sel). Its output feeds the out_data register.
- No other sub-module.

Test Plan:
- Reset mid-burst: rst pulse during OWN0 with out_valid = 1 → all outputs reset immediately; after release, req1 alone is granted 1 cycle later.
- Single requester: req0 = 1, data0 = 8'h11, 8'h22, last on the 2nd beat, out_ready = 1 → gnt0 the cycle after req; out_data 11 then 22 on consecutive cycles; state returns to IDLE; sel = 0.
- Tie/round-robin: req0 = req1 = 1 from reset, each sending 1-beat bursts (last = 1) → grant order 0, 1, 0, 1; sel toggles; no cycle with both grants.
- Forced release: MAX_BEATS = 4, req1 streams 8'hA0..8'hA7 with last1 = 0, req0 = 1 → after 4 beats (A0–A3), grant passes to requester 0; A4 resumes only after requester 0's burst ends.
- Backpressure: out_ready = 0 for 3 cycles during OWN0 with req0 high → out_data held at first beat; counter unchanged; no second beat lost; transfers resume on out_ready = 1.
- Abandon: req1 drops after 1 beat of a 3-beat burst while req0 = 1 → next cycle OWN0; last_served = 1; counter = 0.

Source files
------------

// File: rtl/operand_arbiter_pkg.sv
// Shared definitions for the operand arbiter: FSM state encodings and
// default sizing constants.
package operand_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MAX_BEATS = 4;
    localparam int DATA_W            = 8;

endpackage

// File: rtl/operand_arbiter_mux2.sv
// Existing 2:1 operand mux; c selects e1 when high, e0 when low.
module mux2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] e0,
    input  logic [DATA_W-1:0] e1,
    input  logic              c,
    output logic [DATA_W-1:0] y
);

    assign y = c ? e1 : e0;

endmodule

// File: rtl/operand_arbiter.sv
// Round-robin arbiter sharing the 8-bit operand path between two bursting
// requesters, with a registered valid/ready output stage toward the ALU.
module operand_arbiter
    import operand_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_served_q, last_served_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0] mux_y;
    logic              accept;
    logic              xfer;
    logic              own_req;
    logic              own_last;
    logic              oth_req;
    logic [CNT_W-1:0]  cnt_inc;

    mux2 #(.DATA_W(DATA_W)) u_mux (
        .e0 (data0),
        .e1 (data1),
        .c  (sel_q),
        .y  (mux_y)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        sel_d         = sel_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        accept        = !out_valid_q || out_ready;
        own_req       = (state_q == OWN1) ? req1  : req0;
        own_last      = (state_q == OWN1) ? last1 : last0;
        oth_req       = (state_q == OWN1) ? req0  : req1;
        cnt_inc       = cnt_q + CNT_W'(1);
        xfer          = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0 && (!req1 || last_served_q)) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
                cnt_d = '0;
            end
            OWN0, OWN1: begin
                xfer = own_req && accept;
                if (!own_req || (xfer && (own_last || cnt_inc == CNT_W'(MAX_BEATS)))) begin
                    last_served_d = (state_q == OWN1);
                    cnt_d         = '0;
                    if (oth_req) begin
                        state_d = (state_q == OWN1) ? OWN0 : OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Select follows the owner so the mux is already steered on the first granted cycle.
        if (state_d == OWN1) begin
            sel_d = 1'b1;
        end else if (state_d == OWN0) begin
            sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_served_q <= 1'b1;
            sel_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            sel_q         <= sel_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign gnt0      = (state_q == OWN0);
    assign gnt1      = (state_q == OWN1);
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_operand_arbiter.sv
// Bench for operand_arbiter: directed scenarios plus random bursts, checked
// cycle by cycle against a behavioural owner/queue model.
module tb_operand_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       last0 = 1'b0, last1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       gnt0, gnt1, sel, out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // Pending beats per requester: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       drop0 = 1'b0, drop1 = 1'b0;
    logic       rdy = 1'b1;

    // Reference model: owner is -1 (nobody), 0 or 1
    int         m_owner, m_cnt, m_ls;
    logic       m_sel, m_ov;
    logic [7:0] m_od;

    always #5 clk = ~clk;

    operand_arbiter #(.MAX_BEATS(MAXB), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ls    = 1;
        m_sel   = 1'b0;
        m_ov    = 1'b0;
        m_od    = 8'h00;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".gnt0"},      {7'b0, gnt0},      {7'b0, m_owner == 0});
        chk({ph, ".gnt1"},      {7'b0, gnt1},      {7'b0, m_owner == 1});
        chk({ph, ".sel"},       {7'b0, sel},       {7'b0, m_sel});
        chk({ph, ".out_valid"}, {7'b0, out_valid}, {7'b0, m_ov});
        chk({ph, ".out_data"},  out_data,          m_od);
        chk({ph, ".one_grant"}, {7'b0, gnt0 & gnt1}, 8'h00);
    endtask

    // One clock: drive inputs from the queues, predict, advance, compare.
    task automatic cyc(input string ph);
        logic       rq [2];
        logic       lst[2];
        logic [7:0] dat[2];
        logic       acc;
        int         xi, i;
        int         n_owner, n_cnt, n_ls;
        logic       n_sel, n_ov;
        logic [7:0] n_od;

        req0      = (q0.size() > 0) && !drop0;
        data0     = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        last0     = (q0.size() > 0) ? q0[0][8]   : 1'b0;
        req1      = (q1.size() > 0) && !drop1;
        data1     = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        last1     = (q1.size() > 0) ? q1[0][8]   : 1'b0;
        out_ready = rdy;

        rq[0] = req0;  rq[1] = req1;
        lst[0] = last0; lst[1] = last1;
        dat[0] = data0; dat[1] = data1;

        acc = !m_ov || rdy;
        xi  = -1;
        if (m_owner >= 0) begin
            if (rq[m_owner] && acc) xi = m_owner;
        end

        n_ov = m_ov;
        n_od = m_od;
        if (xi >= 0) begin
            n_ov = 1'b1;
            n_od = dat[xi];
        end else if (rdy) begin
            n_ov = 1'b0;
        end

        n_owner = m_owner;
        n_cnt   = m_cnt;
        n_ls    = m_ls;
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) n_owner = 1 - m_ls;
            else if (rq[0])     n_owner = 0;
            else if (rq[1])     n_owner = 1;
            n_cnt = 0;
        end else begin
            i = m_owner;
            if (!rq[i] || (xi == i && (lst[i] || m_cnt + 1 == MAXB))) begin
                n_ls    = i;
                n_cnt   = 0;
                n_owner = rq[1 - i] ? 1 - i : -1;
            end else if (xi == i) begin
                n_cnt = m_cnt + 1;
            end
        end
        n_sel = m_sel;
        if (n_owner == 1) n_sel = 1'b1;
        else if (n_owner == 0) n_sel = 1'b0;

        @(posedge clk);
        #1;
        if (xi == 0) void'(q0.pop_front());
        else if (xi == 1) void'(q1.pop_front());
        m_owner = n_owner;
        m_cnt   = n_cnt;
        m_ls    = n_ls;
        m_sel   = n_sel;
        m_ov    = n_ov;
        m_od    = n_od;
        check_all(ph);
    endtask

    // Reset is raised between clock edges so the check proves it is asynchronous.
    task automatic do_reset(input string ph);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_all(ph);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_burst(input int who, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            if (who == 0) q0.push_back({(k == len - 1), base + 8'(k)});
            else          q1.push_back({(k == len - 1), base + 8'(k)});
        end
    endtask

    initial begin
        m_reset();
        do_reset("reset");

        // Single requester, two-beat burst
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b1, 8'h22});
        for (int k = 0; k < 5; k++) cyc("single");

        // Tie from reset with one-beat bursts: grants must alternate
        do_reset("reset2");
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, 8'h30 + 8'(k)});
            q1.push_back({1'b1, 8'h40 + 8'(k)});
        end
        for (int k = 0; k < 14; k++) cyc("tie");

        // Forced release after MAX_BEATS
        do_reset("reset3");
        for (int k = 0; k < 8; k++) q1.push_back({1'b0, 8'hA0 + 8'(k)});
        cyc("force");
        q0.push_back({1'b0, 8'hB0});
        q0.push_back({1'b1, 8'hB1});
        for (int k = 0; k < 16; k++) cyc("force");

        // Backpressure during OWN0
        do_reset("reset4");
        push_burst(0, 3, 8'hC0);
        cyc("bp");
        cyc("bp");
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) cyc("bp_stall");
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) cyc("bp_resume");

        // Requester 1 abandons after one beat of a three-beat burst
        do_reset("reset5");
        push_burst(1, 3, 8'hD0);
        cyc("abandon");
        push_burst(0, 2, 8'hE0);
        cyc("abandon");
        drop1 = 1'b1;
        cyc("abandon_drop");
        drop1 = 1'b0;
        for (int k = 0; k < 8; k++) cyc("abandon");

        // Reset mid-burst with a held beat, then requester 1 alone
        do_reset("reset6");
        push_burst(0, 4, 8'hF0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) cyc("midburst");
        q0.delete();
        do_reset("reset_mid");
        rdy = 1'b1;
        q1.push_back({1'b1, 8'h5A});
        for (int k = 0; k < 4; k++) cyc("after_reset");

        // Random bursts, backpressure and abandons
        for (int k = 0; k < 800; k++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0)
                push_burst(0, $urandom_range(1, 6), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 3) == 0)
                push_burst(1, $urandom_range(1, 6), 8'($urandom));
            rdy   = ($urandom_range(0, 3) != 0);
            drop0 = ($urandom_range(0, 15) == 0);
            drop1 = ($urandom_range(0, 15) == 0);
            cyc("random");
        end
        drop0 = 1'b0;
        drop1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
